// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer: captures an N x N result matrix on a load handshake
// and streams its elements row-major over a valid/ready beat interface.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   matrix_size         active dimension N, sampled on the load handshake
//   C                   flattened matrix, element (i,j) at (i*MAX_SIZE+j)*DATA_WIDTH
//   load_valid/ready    load handshake (ready only in IDLE)
//   out_data/row/col    current beat and its indices
//   out_valid/ready     beat handshake
//   out_last            final beat of the matrix
//   busy                high while streaming
//   size_err            one-cycle pulse after an illegal-size load
//
// Optional feature: define MATRIX_SER_SIZE_CHECK_EN to reject matrix_size 0 or
// > MAX_SIZE with a size_err pulse; otherwise oversize loads are clamped.
module matrix_result_serializer #(
    parameter int MAX_SIZE   = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [31:0]                              matrix_size,
    input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  C,
    input  logic                                     load_valid,
    output logic                                     load_ready,
    output logic [DATA_WIDTH-1:0]                    out_data,
    output logic [$clog2(MAX_SIZE)-1:0]              out_row,
    output logic [$clog2(MAX_SIZE)-1:0]              out_col,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     size_err
);
    localparam int RW = $clog2(MAX_SIZE);
    localparam int NE = MAX_SIZE * MAX_SIZE;
    localparam int IW = $clog2(NE);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d, col_q, col_d, last_q, last_d;
    logic [DATA_WIDTH-1:0] buf_q [NE];
    logic [DATA_WIDTH-1:0] buf_d [NE];
    logic [31:0]           n_eff;
    logic                  legal;
    logic [IW-1:0]         idx;

    assign n_eff = (matrix_size > 32'(MAX_SIZE)) ? 32'(MAX_SIZE) : matrix_size;
`ifdef MATRIX_SER_SIZE_CHECK_EN
    logic size_err_q, size_err_d;
    assign legal    = (matrix_size != 32'd0) && (matrix_size <= 32'(MAX_SIZE));
    assign size_err = size_err_q;
`else
    assign legal    = (n_eff != 32'd0);
    assign size_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        buf_d   = buf_q;
`ifdef MATRIX_SER_SIZE_CHECK_EN
        size_err_d = 1'b0;
`endif
        if (state_q == IDLE) begin
            if (load_valid) begin
                for (int e = 0; e < NE; e++) buf_d[e] = C[e*DATA_WIDTH +: DATA_WIDTH];
                row_d   = '0;
                col_d   = '0;
                last_d  = RW'(n_eff - 32'd1);
                state_d = legal ? STREAM : IDLE;
`ifdef MATRIX_SER_SIZE_CHECK_EN
                size_err_d = !legal;
`endif
            end
        end else if (out_ready) begin
            // Row-major walk; the counters are parked at 0 once the last beat leaves.
            col_d = (col_q == last_q) ? '0 : col_q + 1'b1;
            if (col_q == last_q) begin
                row_d   = (row_q == last_q) ? '0 : row_q + 1'b1;
                state_d = (row_q == last_q) ? IDLE : STREAM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= '0;
`ifdef MATRIX_SER_SIZE_CHECK_EN
            size_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
`ifdef MATRIX_SER_SIZE_CHECK_EN
            size_err_q <= size_err_d;
`endif
        end
    end

    // The buffer needs no reset: out_data is masked outside STREAM.
    always_ff @(posedge clk) buf_q <= buf_d;

    assign idx        = IW'(row_q) * IW'(MAX_SIZE) + IW'(col_q);
    assign out_valid  = (state_q == STREAM);
    assign busy       = out_valid;
    assign load_ready = (state_q == IDLE);
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_data   = out_valid ? buf_q[idx] : '0;
    assign out_last   = out_valid && (row_q == last_q) && (col_q == last_q);
endmodule
